// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the slave memory, the master and the APB bridge.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LAST = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-side bus bundle; hreadyin is the shared bus HREADY fed back to the slave.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hreadyin,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hreadyin,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_wstrb_gen.sv
// Maps transfer size and low address bits to a byte-lane strobe and a misalignment flag.
module ahb_wstrb_gen
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misaligned
);

  // Illegal sizes yield an empty strobe; the caller flags them separately.
  always_comb begin
    strb       = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        strb = 4'b0001 << addr_lo;
      end
      HSIZE_HALF: begin
        misaligned = addr_lo[0];
        strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        misaligned = (addr_lo != 2'b00);
        strb       = 4'b1111;
      end
      default: begin
        strb       = 4'b0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave with a small word memory, programmable wait states and two-cycle ERROR responses.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic             hclk,
  input  logic             hresetn,
  ahb_slave_mem_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : {WAIT_CNT_W{1'b0}};

  slv_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            strb_q, strb_d;
  logic                  write_q, write_d;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];

  logic [3:0] strb_s;
  logic       misaligned_s;
  logic       in_range_s;
  logic       size_bad_s;
  logic       err_s;
  logic       accept_s;
  logic       commit_s;
  logic       unused_s;

  ahb_wstrb_gen u_wstrb (
    .hsize      (bus.hsize),
    .addr_lo    (bus.haddr[1:0]),
    .strb       (strb_s),
    .misaligned (misaligned_s)
  );

  // BASE_ADDR is aligned to the window size, so the range check reduces to the upper address bits.
  assign in_range_s = (bus.haddr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
  assign size_bad_s = (bus.hsize > 3'b010);
  assign err_s      = !in_range_s || size_bad_s || misaligned_s;
  assign accept_s   = bus.hsel && bus.hreadyin && bus.htrans[1];
  assign commit_s   = (state_q == S_LAST) && write_q;
  assign unused_s   = ^{bus.hburst, bus.htrans[0]};

  // Next-state, wait counter and address-phase capture.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    strb_d     = strb_q;
    write_d    = write_q;
    case (state_q)
      S_WAIT: begin
        if (wait_cnt_q == {WAIT_CNT_W{1'b0}}) begin
          state_d = S_LAST;
        end else begin
          wait_cnt_d = wait_cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      S_IDLE, S_LAST, S_ERR2: begin
        if (accept_s) begin
          idx_d   = bus.haddr[IDX_W+1:2];
          strb_d  = strb_s;
          write_d = bus.hwrite && !err_s;
          if (err_s) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = S_LAST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte-lane write merge; only the completing OKAY write data phase touches memory.
  always_comb begin
    mem_d = mem_q;
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem_d[idx_q][8*b +: 8] = bus.hwdata[8*b +: 8];
        end else begin
          mem_d[idx_q][8*b +: 8] = mem_q[idx_q][8*b +: 8];
        end
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Control registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= {WAIT_CNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      strb_q     <= 4'b0000;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      strb_q     <= strb_d;
      write_q    <= write_d;
    end
  end

  // Memory array, cleared by reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign bus.hreadyout = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign bus.hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = ((state_q == S_LAST) && !write_q) ? mem_q[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomized scoreboard bench: two slaves (1 and 0 wait states) on one bus, checked against a byte-level memory model.
module tb_ahb_slave_mem;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    int          cycles;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  logic        hclk;
  logic        hresetn;
  logic        mode0;
  logic        in_reset;
  logic        hsel_r;
  logic [31:0] haddr_r;
  logic [1:0]  htrans_r;
  logic        hwrite_r;
  logic [2:0]  hsize_r;
  logic [31:0] hwdata_r;
  logic        hready_s;
  logic [1:0]  resp_s;
  logic [31:0] rdata_s;

  int   checks;
  int   errors;
  int   cyc;
  exp_t exp_q[$];
  logic [31:0] mem1 [16];
  logic [31:0] mem0 [16];

  ahb_slave_mem_if bus1 ();
  ahb_slave_mem_if bus0 ();

  assign bus1.hsel = hsel_r & ~mode0;
  assign bus0.hsel = hsel_r & mode0;
  assign bus1.haddr = haddr_r;   assign bus0.haddr = haddr_r;
  assign bus1.htrans = htrans_r; assign bus0.htrans = htrans_r;
  assign bus1.hwrite = hwrite_r; assign bus0.hwrite = hwrite_r;
  assign bus1.hsize = hsize_r;   assign bus0.hsize = hsize_r;
  assign bus1.hburst = 3'b000;   assign bus0.hburst = 3'b001;
  assign bus1.hwdata = hwdata_r; assign bus0.hwdata = hwdata_r;
  assign hready_s = mode0 ? bus0.hreadyout : bus1.hreadyout;
  assign resp_s   = mode0 ? bus0.hresp : bus1.hresp;
  assign rdata_s  = mode0 ? bus0.hrdata : bus1.hrdata;
  assign bus1.hreadyin = hready_s;
  assign bus0.hreadyin = hready_s;

  ahb_slave_mem #(.DEPTH(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(1)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus1));
  ahb_slave_mem #(.DEPTH(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus0));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] sz);
    logic [32:0] ea;
    ea = {1'b0, a};
    return (ea < {1'b0, BASE}) || (ea >= {1'b0, BASE} + 33'd64) || (sz > 3'd2) ||
           (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 32'd0;
      mem0[i] = 32'd0;
    end
  endtask

  // Wait for an address phase to be taken on the bus (HREADY high before the edge).
  task automatic wait_accept(input string name);
    bit rdy;
    int guard;
    guard = 0;
    do begin
      @(negedge hclk);
      rdy = hready_s;
      @(posedge hclk);
      guard++;
    end while (!rdy && guard < 40);
    if (!rdy) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd);
    exp_t e;
    bit   err;
    int   idx;
    int   lane;
    logic [31:0] word;
    hsel_r   = 1'b1;
    haddr_r  = a;
    htrans_r = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    hwrite_r = w;
    hsize_r  = sz;
    wait_accept("issue");
    err     = exp_err(a, sz);
    idx     = int'((a - BASE) >> 2) & 15;
    e.resp  = err ? 2'b01 : 2'b00;
    e.cycles = (err || !mode0) ? 2 : 1;
    e.rdata = 32'd0;
    if (!err) begin
      word = mode0 ? mem0[idx] : mem1[idx];
      if (w) begin
        for (int b = 0; b < (1 << sz); b++) begin
          lane = int'(a[1:0]) + b;
          word[8*lane +: 8] = wd[8*lane +: 8];
        end
        if (mode0) mem0[idx] = word;
        else       mem1[idx] = word;
      end else begin
        e.rdata = word;
      end
    end
    exp_q.push_back(e);
    hwdata_r = w ? wd : $urandom;
    hsel_r   = 1'b0;
    htrans_r = 2'b00;
  endtask

  task automatic idle_cycle(input int kind);
    hsel_r   = (kind != 0);
    htrans_r = (kind == 2) ? 2'b01 : 2'b00;
    haddr_r  = BASE + 32'($urandom_range(0, 15) * 4);
    hwrite_r = 1'($urandom_range(0, 1));
    wait_accept("idle");
    hsel_r   = 1'b0;
    htrans_r = 2'b00;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      idle_cycle(0);
      guard++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic random_beats(input int n);
    logic [31:0] a;
    logic [2:0]  sz;
    int idx, off, r;
    for (int k = 0; k < n; k++) begin
      sz  = 3'($urandom_range(0, 2));
      idx = $urandom_range(0, 15);
      off = (sz == 3'd0) ? $urandom_range(0, 3) : (sz == 3'd1) ? 2 * $urandom_range(0, 1) : 0;
      a   = BASE + 32'(idx * 4 + off);
      r   = $urandom_range(0, 11);
      if (r == 9) begin
        sz = 3'($urandom_range(1, 2));
        a  = BASE + 32'(idx * 4 + 1 + 2 * $urandom_range(0, 1));
      end else if (r == 10) begin
        sz = 3'($urandom_range(3, 7));
      end else if (r == 11) begin
        case ($urandom_range(0, 3))
          0:       a = 32'h8000_0040 + 32'(idx * 4);
          1:       a = 32'h7FFF_FFFC;
          2:       a = 32'(idx * 4);
          default: a = BASE ^ (32'h1 << $urandom_range(6, 31));
        endcase
      end
      issue(a, 1'($urandom_range(0, 1)), sz, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 2));
    end
  endtask

  // Scoreboard monitor: samples on the falling edge and retires one beat per completed data phase.
  always @(negedge hclk) begin
    if (in_reset) begin
      cyc = 0;
    end else if (exp_q.size() == 0) begin
      check("idle_ready", {31'd0, hready_s}, 32'd1);
      check("idle_resp", {30'd0, resp_s}, 32'd0);
      check("idle_rdata", rdata_s, 32'd0);
    end else begin
      cyc++;
      if (hready_s) begin
        check("beat_cycles", cyc, exp_q[0].cycles);
        check("beat_resp", {30'd0, resp_s}, {30'd0, exp_q[0].resp});
        check("beat_rdata", rdata_s, exp_q[0].rdata);
        void'(exp_q.pop_front());
        cyc = 0;
      end else begin
        check("stall_resp", {30'd0, resp_s}, {30'd0, exp_q[0].resp});
        check("stall_rdata", rdata_s, 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "bench timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    mode0 = 1'b0; in_reset = 1'b1; hresetn = 1'b0;
    hsel_r = 1'b0; haddr_r = 32'd0; htrans_r = 2'b00; hwrite_r = 1'b0;
    hsize_r = 3'b010; hwdata_r = 32'd0;
    model_clear();
    repeat (3) @(posedge hclk);
    #1;
    check("rst_ready1", {31'd0, bus1.hreadyout}, 32'd1);
    check("rst_resp1", {30'd0, bus1.hresp}, 32'd0);
    check("rst_rdata1", bus1.hrdata, 32'd0);
    check("rst_ready0", {31'd0, bus0.hreadyout}, 32'd1);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    in_reset = 1'b0;

    issue(32'h8000_0004, 1'b1, 3'b010, 32'hDEAD_BEEF);
    issue(32'h8000_0004, 1'b0, 3'b010, 32'd0);
    issue(32'h8000_0009, 1'b1, 3'b000, 32'h1234_A5CD);
    issue(32'h8000_0008, 1'b0, 3'b010, 32'd0);
    issue(32'h8000_0000, 1'b1, 3'b010, 32'h1111_2222);
    issue(32'h8000_0040, 1'b0, 3'b010, 32'd0);
    issue(32'h8000_0040, 1'b1, 3'b010, 32'hFFFF_FFFF);
    issue(32'h8000_0001, 1'b1, 3'b001, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 1'b0, 3'b010, 32'd0);
    issue(32'h8000_003C, 1'b1, 3'b010, 32'h0BAD_F00D);
    issue(32'h8000_003C, 1'b0, 3'b010, 32'd0);
    drain();

    mode0 = 1'b1;
    issue(32'h8000_0000, 1'b1, 3'b010, 32'hCAFE_F00D);
    issue(32'h8000_0000, 1'b0, 3'b010, 32'd0);
    random_beats(60);
    drain();
    mode0 = 1'b0;

    // Abandon a write in its wait cycle with an asynchronous reset.
    issue(32'h8000_0010, 1'b1, 3'b010, 32'h5555_AAAA);
    drain();
    hsel_r = 1'b1; haddr_r = 32'h8000_0010; htrans_r = 2'b10; hwrite_r = 1'b1; hsize_r = 3'b010;
    wait_accept("rst_mid");
    hwdata_r = 32'h1234_5678;
    hsel_r = 1'b0; htrans_r = 2'b00;
    check("pre_reset_stall", {31'd0, hready_s}, 32'd0);
    in_reset = 1'b1;
    hresetn  = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, hready_s}, 32'd1);
    check("async_rst_rdata", rdata_s, 32'd0);
    check("async_rst_resp", {30'd0, resp_s}, 32'd0);
    exp_q.delete();
    model_clear();
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    in_reset = 1'b0;
    issue(32'h8000_0010, 1'b0, 3'b010, 32'd0);
    drain();

    random_beats(200);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite slave that answers the transfers driven by the team's `ahb_master`. It holds a small word-addressed register memory and inserts a programmable number of wait states, so the master's `hreadyout` handshake can be exercised. It returns OKAY or two-cycle ERROR responses and is the AHB end against which the AHB-to-APB bridge masters are verified.

## Interface
- `DEPTH`, 16: number of 32-bit words; power of two, 2–256.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0; must be aligned to `DEPTH*4`.
- `WAIT_STATES`, 1: number of `hreadyout=0` cycles before each OKAY data phase completes; range 0–15.
- `hclk` in 1: the single clock.
- `hresetn` in 1: asynchronous, active-low reset.
- `hsel` in 1: slave select.
- `haddr` in 32: byte address.
- `htrans` in 2: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 000 byte, 001 half, 010 word; anything else is illegal.
- `hburst` in 3: ignored; each beat is handled independently.
- `hwdata` in 32: write data, valid in the data phase.
- `hreadyin` in 1: bus HREADY; a previous transfer has completed.
- `hreadyout` out 1: 0 stalls the current data phase.
- `hresp` out 2: OKAY 00, ERROR 01; 10 and 11 are never driven.
- `hrdata` out 32: read data, valid when `hreadyout=1` in a read data phase, else 0.

## Operation
- **Address-phase accept:** `hsel & hreadyin & htrans[1]`. On accept, register address, `hwrite` and `hsize`, and check the transfer.
- **Error conditions:**
  - address outside `[BASE_ADDR, BASE_ADDR+DEPTH*4)`;
  - `hsize > 010`;
  - misalignment: half-word with `haddr[0]=1`, or word with `haddr[1:0]≠0`.
- **Ignored transfers:** IDLE, BUSY, or `hsel=0` with `hreadyin=1`. No data phase; stay in or return to `S_IDLE` with OKAY and zero waits.
- **State machine:**
  - `S_IDLE`: accepted legal transfer → `S_WAIT` if `WAIT_STATES>0`, else `S_LAST`. Accepted illegal transfer → `S_ERR1`.
  - `S_WAIT`: `hreadyout=0`; the wait counter loads `WAIT_STATES-1` and decrements; at 0 → `S_LAST`.
  - `S_LAST`: `hreadyout=1`, OKAY. A write commits on this edge. A new accept in this cycle re-enters `S_WAIT`, `S_LAST` or `S_ERR1`; otherwise → `S_IDLE`.
  - `S_ERR1`: `hreadyout=0`, `hresp=ERROR` → `S_ERR2`.
  - `S_ERR2`: `hreadyout=1`, `hresp=ERROR`. Same accept rules as `S_LAST`.
- **Writes:**
  - byte lanes are derived from `hsize` and the registered `haddr[1:0]`; only those lanes of `mem[addr_q[log2(DEPTH)+1:2]]` update;
  - errored writes never modify memory.
- **Reads:** `hrdata` is the full word `mem[idx_q]`, driven combinationally during `S_LAST` only. The master selects the lanes.
- **Read after write:** a read data phase following a write to the same word returns the new data, because the write commits at the `S_LAST` edge.

## Timing
- **Reset values:** `hreadyout=1`, `hresp=00`, `hrdata=0`, state `S_IDLE`, wait counter 0, all memory words 0.
- **Latency:** one accepted beat occupies `WAIT_STATES+1` data-phase cycles for OKAY and 2 cycles for ERROR.
- **Back-to-back:** sustained throughput is one beat per `WAIT_STATES+1` cycles.
- **`hreadyin`:** the slave never samples an address phase while `hreadyin=0`, even if `hsel=1`.
- **`hwdata`:** sampled only on the completing `S_LAST` edge; it may change during wait cycles.
- **Reset mid-operation:** asserting `hresetn` during `S_WAIT`, `S_LAST` or `S_ERR1` abandons the beat. No memory write; outputs go to reset values immediately (asynchronously).
- **Boundary addresses:**
  - `BASE_ADDR+DEPTH*4-4` is the last legal word;
  - `BASE_ADDR+DEPTH*4` errors;
  - the range check is on the full 32-bit address, with no aliasing.

## Structure
- `ahb_pkg`: `htrans_t`, `hresp_t` and `hsize_t` enums; `HRESP_OKAY` and `HRESP_ERROR` constants. Shared with `ahb_master` and the bridge.
- Sub-module `ahb_wstrb_gen`: combinational; maps `hsize` and `addr[1:0]` to a 4-bit lane strobe plus a misaligned flag.
- The FSM, wait counter and memory array live in `ahb_slave_mem`.

## Test plan
- Reset with `WAIT_STATES=1`, then a word write of 32'hDEAD_BEEF to 32'h8000_0004, then a read of the same address → write shows 1 wait cycle; read returns 32'hDEAD_BEEF with `hresp=00`.
- Byte write of 8'hA5 to 32'h8000_0009 over a zeroed word → a read of 32'h8000_0008 returns 32'h0000_A500.
- Word read of 32'h8000_0040 with `DEPTH=16` → `hreadyout` sequence 0,1 with `hresp=01` on both cycles; a word write to the same address leaves memory unchanged.
- Half-word write to 32'h8000_0001 → ERROR response; memory unchanged.
- Back-to-back NONSEQ write to 8000_0000 then read from 8000_0000 with `WAIT_STATES=0` → each beat takes 1 cycle; the read returns the just-written value.
- `hresetn` pulsed low during a write's wait cycle → `hreadyout=1` and `hrdata=0` immediately; a subsequent read of that address returns 0.
